// File: rtl/exa_vc_out_sched_if.sv
// Link-side bundle of the VC output scheduler: per-VC FIFO head view plus the registered output word.
// master = scheduler, slave = FIFO bank / downstream link.
interface exa_vc_out_sched_if #(
    parameter int NUM_VC = 4,
    parameter int DWIDTH = 32
);
    localparam int VCW = $clog2(NUM_VC);

    logic [NUM_VC-1:0]        i_vc_empty;
    logic [NUM_VC*DWIDTH-1:0] i_vc_rd_data;
    logic [NUM_VC-1:0]        i_vc_tail;
    logic [NUM_VC-1:0]        o_vc_rd_en;
    logic                     o_valid;
    logic [DWIDTH-1:0]        o_data;
    logic                     o_tail;
    logic [VCW-1:0]           o_vc_id;

    modport master (
        input  i_vc_empty, i_vc_rd_data, i_vc_tail,
        output o_vc_rd_en, o_valid, o_data, o_tail, o_vc_id
    );

    modport slave (
        output i_vc_empty, i_vc_rd_data, i_vc_tail,
        input  o_vc_rd_en, o_valid, o_data, o_tail, o_vc_id
    );
endinterface

// File: rtl/exa_vc_out_sched.sv
// Packet-atomic round-robin output scheduler with per-VC downstream credit counters.
// Optional per-VC packet counters are built when EXA_VC_OUT_SCHED_STATS_EN is defined.
module exa_vc_out_sched #(
    parameter int  NUM_VC  = 4,
    parameter int  DWIDTH  = 32,
    parameter int  CREDITS = 8,
    localparam int CWIDTH  = $clog2(CREDITS + 1),
    localparam int VCW     = $clog2(NUM_VC)
) (
    input  logic                     clk,
    input  logic                     arst_n,
    exa_vc_out_sched_if.master       vc_if,
    input  logic [NUM_VC-1:0]        i_credit_ret,
    output logic [NUM_VC*CWIDTH-1:0] o_credit,
    output logic                     o_credit_err,
    output logic [NUM_VC*32-1:0]     o_pkt_cnt
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t            state, state_nxt;
    logic [VCW-1:0]    grant, grant_nxt;
    logic [VCW-1:0]    rr_ptr, rr_nxt;
    logic              pop;
    logic [NUM_VC-1:0] pop_vec;
    logic [NUM_VC-1:0] elig;
    logic [NUM_VC-1:0] credit_ovf;
    logic [CWIDTH-1:0] credit [NUM_VC];
    logic [DWIDTH-1:0] head_data;

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            elig[v] = ~vc_if.i_vc_empty[v] & (credit[v] != '0);
        end
    end

    // Round-robin search starts one past the VC that sent the last tail.
    logic           arb_found;
    logic [VCW-1:0] arb_sel;
    int             arb_idx;

    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_idx   = 0;
        for (int k = 1; k <= NUM_VC; k++) begin
            arb_idx = (int'(rr_ptr) + k) % NUM_VC;
            if (!arb_found && elig[VCW'(arb_idx)]) begin
                arb_found = 1'b1;
                arb_sel   = VCW'(arb_idx);
            end
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt    = rr_ptr;
        pop       = 1'b0;
        pop_vec   = '0;
        unique case (state)
            IDLE: begin
                if (arb_found) begin
                    grant_nxt = arb_sel;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                pop          = elig[grant];
                pop_vec[grant] = pop;
                if (pop && vc_if.i_vc_tail[grant]) begin
                    rr_nxt    = grant;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign vc_if.o_vc_rd_en = pop_vec;
    assign head_data        = vc_if.i_vc_rd_data[grant*DWIDTH +: DWIDTH];

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= VCW'(NUM_VC - 1);
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vc_if.o_valid <= 1'b0;
            vc_if.o_data  <= '0;
            vc_if.o_tail  <= 1'b0;
            vc_if.o_vc_id <= '0;
        end else begin
            vc_if.o_valid <= pop;
            if (pop) begin
                vc_if.o_data  <= head_data;
                vc_if.o_tail  <= vc_if.i_vc_tail[grant];
                vc_if.o_vc_id <= grant;
            end
        end
    end

    // A simultaneous pop and return cancel; a return to a full counter is flagged, not counted.
    for (genvar v = 0; v < NUM_VC; v++) begin : g_credit
        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                credit[v] <= CWIDTH'(CREDITS);
            end else if (pop_vec[v] && !i_credit_ret[v]) begin
                credit[v] <= credit[v] - CWIDTH'(1);
            end else if (!pop_vec[v] && i_credit_ret[v] && credit[v] != CWIDTH'(CREDITS)) begin
                credit[v] <= credit[v] + CWIDTH'(1);
            end
        end

        assign credit_ovf[v] = i_credit_ret[v] & ~pop_vec[v] & (credit[v] == CWIDTH'(CREDITS));
        assign o_credit[v*CWIDTH +: CWIDTH] = credit[v];
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_credit_err <= 1'b0;
        end else if (|credit_ovf) begin
            o_credit_err <= 1'b1;
        end
    end

`ifdef EXA_VC_OUT_SCHED_STATS_EN
    for (genvar v = 0; v < NUM_VC; v++) begin : g_stats
        logic [31:0] pkt_cnt;

        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                pkt_cnt <= '0;
            end else if (pop_vec[v] && vc_if.i_vc_tail[v]) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end

        assign o_pkt_cnt[v*32 +: 32] = pkt_cnt;
    end
`else
    assign o_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_exa_vc_out_sched.sv
// Scoreboard bench for exa_vc_out_sched: queue-modelled VC FIFOs, expected words queued at stimulus time.
module tb_exa_vc_out_sched;
    localparam int NUM_VC = 4;
    localparam int DWIDTH = 32;
    localparam int CW     = 4;

    typedef struct {
        logic [31:0] data;
        logic        tail;
        logic [1:0]  vc;
        int          cyc;
    } exp_t;

    typedef logic [32:0] fw_q_t [$];

    logic              clk;
    logic              arst_n;
    logic [NUM_VC-1:0] credit_ret;
    logic [NUM_VC*CW-1:0] credit_w;
    logic              credit_err;
    logic [NUM_VC*32-1:0] pkt_cnt;

    exa_vc_out_sched_if #(.NUM_VC(NUM_VC), .DWIDTH(DWIDTH)) vc_if ();

    exa_vc_out_sched #(.NUM_VC(NUM_VC), .DWIDTH(DWIDTH), .CREDITS(8)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .vc_if        (vc_if),
        .i_credit_ret (credit_ret),
        .o_credit     (credit_w),
        .o_credit_err (credit_err),
        .o_pkt_cnt    (pkt_cnt)
    );

    fw_q_t       fq [NUM_VC];
    exp_t        sb [$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          out_cnt = 0;
    logic [3:0]  pend = '0;
    int          t0;
    int          base;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic logic [31:0] mkw(input int v, input int id, input int i);
        return {4'hA, 4'(v), 8'(id), 16'(i)};
    endfunction

    function automatic logic [3:0] cr(input int v);
        logic [NUM_VC*CW-1:0] c;
        c = credit_w;
        return c[v*CW +: CW];
    endfunction

    function automatic logic [31:0] pc(input int v);
        logic [NUM_VC*32-1:0] p;
        p = pkt_cnt;
        return p[v*32 +: 32];
    endfunction

    task automatic refresh();
        logic [NUM_VC-1:0]        e;
        logic [NUM_VC-1:0]        t;
        logic [NUM_VC*DWIDTH-1:0] d;
        e = '1;
        t = '0;
        d = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (fq[v].size() != 0) begin
                e[v] = 1'b0;
                d[v*DWIDTH +: DWIDTH] = fq[v][0][31:0];
                t[v] = fq[v][0][32];
            end
        end
        vc_if.i_vc_empty   = e;
        vc_if.i_vc_rd_data = d;
        vc_if.i_vc_tail    = t;
    endtask

    task automatic add_pkt(input int v, input int len, input int id);
        for (int i = 0; i < len; i++) fq[v].push_back({(i == len - 1), mkw(v, id, i)});
    endtask

    task automatic exp_pkt(input int v, input int id, input int first, input int n, input int len, input int cyc0);
        exp_t e;
        for (int i = first; i < first + n; i++) begin
            e.data = mkw(v, id, i);
            e.tail = (i == len - 1);
            e.vc   = 2'(v);
            e.cyc  = (cyc0 < 0) ? -1 : cyc0 + (i - first);
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        arst_n = 1'b0;
        sb.delete();
        for (int v = 0; v < NUM_VC; v++) fq[v].delete();
        refresh();
        @(posedge clk);
        #3;
        arst_n = 1'b1;
    endtask

    // FIFO model: pops sampled mid-cycle, applied just after the edge that commits them.
    initial begin
        forever begin
            @(negedge clk);
            pend = vc_if.o_vc_rd_en;
            @(posedge clk);
            #1;
            for (int v = 0; v < NUM_VC; v++) begin
                if (pend[v]) begin
                    check("pop_on_empty", (fq[v].size() == 0) ? 1 : 0, 0);
                    if (fq[v].size() != 0) void'(fq[v].pop_front());
                end
            end
            refresh();
        end
    end

    // Output monitor against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (arst_n && vc_if.o_valid) begin
                out_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_word", vc_if.o_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", vc_if.o_data, e.data);
                    check("out_tail", vc_if.o_tail, e.tail);
                    check("out_vc_id", vc_if.o_vc_id, e.vc);
                    if (e.cyc >= 0) check("out_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n     = 1'b0;
        credit_ret = '0;
        refresh();
        repeat (3) @(posedge clk);
        #3;
        arst_n = 1'b1;

        // Idle after reset with empty FIFOs.
        repeat (10) begin
            @(negedge clk);
            check("idle_rd_en", vc_if.o_vc_rd_en, 0);
            check("idle_valid", vc_if.o_valid, 0);
        end
        for (int v = 0; v < NUM_VC; v++) check("rst_credit", cr(v), 8);
        check("rst_err", credit_err, 0);
        check("rst_data", vc_if.o_data, 0);
        check("rst_tail", vc_if.o_tail, 0);
        check("rst_vc_id", vc_if.o_vc_id, 0);
        check("rst_pkt_cnt", pkt_cnt[63:0], 0);

        // Two 3-word packets on VC0 and VC2 with one arbitration bubble between.
        @(posedge clk);
        #2;
        t0 = cyc;
        add_pkt(0, 3, 1);
        add_pkt(2, 3, 1);
        refresh();
        exp_pkt(0, 1, 0, 3, 3, t0 + 2);
        exp_pkt(2, 1, 0, 3, 3, t0 + 6);
        wait_drain("drain_two_pkts");
        check("credit0_after", cr(0), 5);
        check("credit2_after", cr(2), 5);
        check("credit1_after", cr(1), 8);

        // Credit stall on a 12-word VC1 packet holds the grant; VC3 waits.
        do_reset();
        @(posedge clk);
        #2;
        t0   = cyc;
        base = out_cnt;
        add_pkt(1, 12, 2);
        add_pkt(3, 2, 2);
        refresh();
        exp_pkt(1, 2, 0, 8, 12, t0 + 2);
        exp_pkt(1, 2, 8, 4, 12, -1);
        exp_pkt(3, 2, 0, 2, 2, -1);
        repeat (16) @(negedge clk);
        check("stall_words_out", out_cnt - base, 8);
        check("stall_valid", vc_if.o_valid, 0);
        check("stall_rd_en", vc_if.o_vc_rd_en, 0);
        check("stall_credit1", cr(1), 0);
        check("stall_credit3", cr(3), 8);
        repeat (4) begin
            @(posedge clk);
            #2;
            credit_ret = 4'b0010;
            @(posedge clk);
            #2;
            credit_ret = '0;
        end
        wait_drain("drain_stall");
        check("stall_credit1_end", cr(1), 0);
        check("stall_credit3_end", cr(3), 6);

        // Continuous single-word packets on all VCs rotate strictly.
        do_reset();
        @(posedge clk);
        #2;
        t0 = cyc;
        for (int p = 0; p < 3; p++)
            for (int v = 0; v < NUM_VC; v++) add_pkt(v, 1, p);
        refresh();
        for (int p = 0; p < 3; p++)
            for (int v = 0; v < NUM_VC; v++) exp_pkt(v, p, 0, 1, 1, t0 + 2 + 2 * (p * NUM_VC + v));
        wait_drain("drain_rotation");
        for (int v = 0; v < NUM_VC; v++) begin
            check("rot_credit", cr(v), 5);
`ifdef EXA_VC_OUT_SCHED_STATS_EN
            check("rot_pkt_cnt", pc(v), 3);
`else
            check("rot_pkt_cnt", pc(v), 0);
`endif
        end

        // Pop and return in the same cycle; return to a full counter.
        do_reset();
        @(posedge clk);
        #2;
        t0 = cyc;
        add_pkt(0, 3, 5);
        refresh();
        exp_pkt(0, 5, 0, 3, 3, t0 + 2);
        @(posedge clk);
        #2;
        credit_ret = 4'b0001;
        @(posedge clk);
        #2;
        credit_ret = '0;
        @(negedge clk);
        check("pop_ret_credit0", cr(0), 8);
        check("pop_ret_err", credit_err, 0);
        wait_drain("drain_pop_ret");
        check("pop_ret_credit0_end", cr(0), 6);
        @(posedge clk);
        #2;
        credit_ret = 4'b0100;
        @(posedge clk);
        #2;
        credit_ret = '0;
        @(negedge clk);
        check("full_ret_credit2", cr(2), 8);
        check("full_ret_err", credit_err, 1);
        repeat (2) begin
            @(posedge clk);
            #2;
            credit_ret = 4'b0001;
            @(posedge clk);
            #2;
            credit_ret = '0;
        end
        repeat (3) @(negedge clk);
        check("refill_credit0", cr(0), 8);
        check("err_sticky", credit_err, 1);

        // Reset during the second word of a 4-word VC1 packet.
        do_reset();
        @(posedge clk);
        #2;
        t0 = cyc;
        add_pkt(1, 4, 6);
        refresh();
        exp_pkt(1, 6, 0, 4, 4, t0 + 2);
        repeat (3) @(posedge clk);
        #3;
        arst_n = 1'b0;
        #1;
        check("mid_rst_valid", vc_if.o_valid, 0);
        check("mid_rst_rd_en", vc_if.o_vc_rd_en, 0);
        check("mid_rst_data", vc_if.o_data, 0);
        check("mid_rst_credit1", cr(1), 8);
        check("mid_rst_sb_left", sb.size(), 3);
        check("mid_rst_fifo_left", fq[1].size(), 2);
        sb.delete();
        add_pkt(0, 2, 6);
        refresh();
        exp_pkt(0, 6, 0, 2, 2, -1);
        exp_pkt(1, 6, 2, 2, 4, -1);
        @(posedge clk);
        #3;
        arst_n = 1'b1;
        wait_drain("drain_after_rst");
        check("post_rst_credit0", cr(0), 6);
        check("post_rst_credit1", cr(1), 6);
        @(posedge clk);
        #2;
        add_pkt(0, 1, 7);
        refresh();
        exp_pkt(0, 7, 0, 1, 1, -1);
        wait_drain("drain_second_vc0");
        check("post_rst_credit0_end", cr(0), 5);
`ifdef EXA_VC_OUT_SCHED_STATS_EN
        check("pkt_cnt_vc0", pc(0), 2);
        check("pkt_cnt_vc1", pc(1), 1);
`else
        check("pkt_cnt_vc0", pc(0), 0);
        check("pkt_cnt_vc1", pc(1), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/exa_vc_out_sched.md
Name: exa_vc_out_sched

Overview:
- Output-port scheduler for the virtual-channel switch. It shares one output link between NUM_VC per-VC input FIFOs.
- Each FIFO is an exa_fifo instance with combinational read data and ALL_REGD=1.
- Round-robin arbitration is packet-atomic: a grant is held until the tail word has been sent.
- Per-VC downstream credit counters give lossless, credit-based flow control toward the next hop.

Parameters:
- NUM_VC, 4, number of virtual channels/FIFOs arbitrated (>=2).
- DWIDTH, 32, data word width.
- CREDITS, 8, downstream buffer depth per VC in words. Reset value and ceiling of each credit counter.
- CWIDTH, $clog2(CREDITS+1), localparam, credit counter width.

Ports:
- clk  in  1  clock
- arst_n  in  1  reset, asynchronous, active-low
- i_vc_empty  in  NUM_VC  per-VC FIFO o_empty
- i_vc_rd_data  in  NUM_VC*DWIDTH  per-VC FIFO o_rd_data (head word), VC v at [v*DWIDTH +: DWIDTH]
- i_vc_tail  in  NUM_VC  per-VC tail flag of the head word
- o_vc_rd_en  out  NUM_VC  per-VC FIFO i_rd_en (pop), combinational
- o_valid  out  1  output word valid, registered
- o_data  out  DWIDTH  output word, registered
- o_tail  out  1  output word is a packet tail, registered
- o_vc_id  out  $clog2(NUM_VC)  VC of the output word, registered
- i_credit_ret  in  NUM_VC  one-cycle pulse per freed downstream word
- o_credit  out  NUM_VC*CWIDTH  current credit counters
- o_credit_err  out  1  sticky: a credit was returned to a full counter
- o_pkt_cnt  out  NUM_VC*32  per-VC forwarded-packet counters (optional feature)

Behaviour:
- Reset (arst_n low, asynchronous):
  - state=IDLE, grant=0, rr_ptr=NUM_VC-1.
  - o_valid=0, o_data=0, o_tail=0, o_vc_id=0, o_credit_err=0.
  - Every credit counter = CREDITS; o_pkt_cnt all 0.
  - Reset mid-packet abandons the packet; FIFO contents are untouched.
- Eligibility: elig[v] = ~i_vc_empty[v] & (credit[v] != 0).
- IDLE:
  - o_vc_rd_en=0.
  - If any elig, grant <= first elig VC searching rr_ptr+1, rr_ptr+2, ... modulo NUM_VC; state <= XFER.
  - Otherwise stay in IDLE.
- XFER:
  - pop = elig[grant]; o_vc_rd_en[grant] = pop; all other rd_en bits = 0.
  - On pop: next cycle o_valid=1, o_data=i_vc_rd_data[grant], o_tail=i_vc_tail[grant], o_vc_id=grant.
  - No pop (empty or zero credits): o_valid=0 next cycle, grant is held. No other VC is served mid-packet.
  - Pop with i_vc_tail[grant]=1: rr_ptr <= grant, state <= IDLE.
- Latency:
  - FIFO head to o_valid is 1 cycle.
  - Each packet costs one IDLE arbitration bubble.
  - Sustained throughput is 1 word/cycle within a packet.
- Credits, per VC, evaluated each cycle:
  - pop only: -1.
  - return only: +1.
  - pop and return in the same cycle: unchanged.
  - Return with counter already at CREDITS and no pop: counter stays at CREDITS, o_credit_err <= 1 (cleared only by reset).
  - A pop never occurs at 0 credits, so counters cannot underflow.
- o_credit reflects registered counter values.
- Single-word packets (head is also tail) run IDLE -> XFER -> IDLE.

Optional Feature:
- Macro EXA_VC_OUT_SCHED_STATS_EN.
- Defined: per-VC 32-bit counter increments on each popped tail word and wraps at 2^32. o_pkt_cnt exposes the counters.
- Undefined: counter logic is not built; o_pkt_cnt is tied to 0. Port list is identical either way.

Test Plan:
- Reset, all FIFOs empty -> o_valid=0, o_credit all 8, state IDLE, o_vc_rd_en=0 indefinitely.
- VC0 and VC2 each hold one 3-word packet, credits 8 -> VC0 packet first (words on cycles 2,3,4 after arbitration start), one bubble, then VC2 packet. o_vc_id 0,0,0 then 2,2,2; credit[0]=credit[2]=5.
- VC1 holds a 12-word packet, no credit returns -> 8 words out, then o_valid=0 with grant held on VC1. A VC3 packet present meanwhile is not served. Pulse i_credit_ret[1] 4x -> remaining 4 words sent, tail seen, then VC3 is granted.
- All 4 VCs continuously hold 1-word packets -> grant order 0,1,2,3,0,1... with strict rotation.
- Pop on VC0 coinciding with i_credit_ret[0] -> credit[0] unchanged. i_credit_ret[2] with credit[2]=8 -> credit stays 8, o_credit_err=1 and remains 1.
- arst_n asserted during word 2 of a 4-word VC1 packet -> outputs reset immediately, credits=8. After release, arbitration restarts from VC0. With EXA_VC_OUT_SCHED_STATS_EN, o_pkt_cnt[0] counts 2 after two VC0 packets.
